// File: rtl/ram_fifo_pkg.sv
// Shared types and default sizing for the RAM-backed FIFO controller.
package ram_fifo_pkg;

    localparam int unsigned DEPTH      = 8;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WR,
        GNT_RD
    } grant_t;

endpackage

// File: rtl/ram_fifo_arb.sv
// Two-way round-robin arbiter between FIFO push and pop onto the single RAM port.
module ram_fifo_arb
    import ram_fifo_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   wr_elig,
    input  logic   rd_elig,
    output grant_t grant
);

    grant_t last_q, last_d;

    always_comb begin
        grant = GNT_NONE;
        if (wr_elig && rd_elig) begin
            grant = (last_q == GNT_WR) ? GNT_RD : GNT_WR;
        end else if (wr_elig) begin
            grant = GNT_WR;
        end else if (rd_elig) begin
            grant = GNT_RD;
        end
    end

    always_comb begin
        last_d = last_q;
        if (grant != GNT_NONE) begin
            last_d = grant;
        end
    end

    // Resetting to RD hands the first contested cycle to the writer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= GNT_RD;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a single-port RAM: pointers, occupancy, RAM access regs.
// Optional RAM_FIFO_CTRL_LEVEL_EN adds level and almost_full outputs.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    input  logic              pop_req,
    output logic              pop_ready,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_data_valid,
    output logic              full,
    output logic              empty,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef RAM_FIFO_CTRL_LEVEL_EN
    ,
    output logic [ADDR_W:0]   level,
    output logic              almost_full
`endif
);

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_d, re_d, valid_q;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              push_elig, pop_elig;
    grant_t            grant;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // Gating with rst_n keeps both handshakes closed while reset is held.
    assign push_elig = rst_n && push_valid && !full;
    assign pop_elig  = rst_n && pop_req && !empty;

    ram_fifo_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_elig (push_elig),
        .rd_elig (pop_elig),
        .grant   (grant)
    );

    assign push_ready     = (grant == GNT_WR);
    assign pop_ready      = (grant == GNT_RD);
    assign pop_data       = ram_rdata;
    assign pop_data_valid = valid_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = ram_addr;
        wdata_d  = ram_wdata;
        we_d     = 1'b0;
        re_d     = 1'b0;
        case (grant)
            GNT_WR: begin
                we_d     = 1'b1;
                addr_d   = wr_ptr_q;
                wdata_d  = push_data;
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
            end
            GNT_RD: begin
                re_d     = 1'b1;
                addr_d   = rd_ptr_q;
                rd_ptr_d = rd_ptr_q + 1'b1;
                count_d  = count_q - 1'b1;
            end
            default: ;
        endcase
    end

    // ram_re is the first stage of the read-valid pipe; valid_q lines up with RAM data_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ram_we    <= 1'b0;
            ram_re    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            valid_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ram_we    <= we_d;
            ram_re    <= re_d;
            ram_addr  <= addr_d;
            ram_wdata <= wdata_d;
            valid_q   <= ram_re;
        end
    end

`ifdef RAM_FIFO_CTRL_LEVEL_EN
    assign level       = count_q;
    assign almost_full = (count_q >= FULL_CNT - 1'b1);
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: queue-based reference model plus directed literal checks.
// Covers RAM_FIFO_CTRL_LEVEL_EN outputs when that macro is defined.
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       push_valid, push_ready, pop_req, pop_ready, pop_data_valid;
    logic [7:0] push_data, pop_data, ram_wdata, ram_rdata;
    logic       full, empty, ram_we, ram_re;
    logic [2:0] ram_addr;
`ifdef RAM_FIFO_CTRL_LEVEL_EN
    logic [3:0] level;
    logic       almost_full;
`endif

    int checks = 0;
    int failures = 0;

    ram_fifo_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .push_valid     (push_valid),
        .push_data      (push_data),
        .push_ready     (push_ready),
        .pop_req        (pop_req),
        .pop_ready      (pop_ready),
        .pop_data       (pop_data),
        .pop_data_valid (pop_data_valid),
        .full           (full),
        .empty          (empty),
        .ram_we         (ram_we),
        .ram_re         (ram_re),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata)
`ifdef RAM_FIFO_CTRL_LEVEL_EN
        ,
        .level          (level),
        .almost_full    (almost_full)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural 8x8 RAM with registered read port.
    logic [7:0] mem [8];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, plus the RAM-side view expected this cycle.
    logic [7:0] m_q[$];
    int         m_wr, m_rd;
    bit         m_last_wr, m_we, m_re, m_valid;
    logic [2:0] m_addr;
    logic [7:0] m_wdata, m_vdata, m_rd_word;

    task automatic model_reset();
        m_q.delete();
        m_wr = 0; m_rd = 0; m_last_wr = 0;
        m_we = 0; m_re = 0; m_valid = 0;
        m_addr = 3'd0; m_wdata = 8'd0;
    endtask

    // 0 = no grant, 1 = push, 2 = pop.
    function automatic int exp_grant();
        bit pe, re;
        pe = push_valid && (m_q.size() < 8);
        re = pop_req && (m_q.size() > 0);
        if (pe && re) return m_last_wr ? 2 : 1;
        if (pe) return 1;
        if (re) return 2;
        return 0;
    endfunction

    initial begin
        int g;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_reset();
                chk("rst_push_ready", 8'(push_ready), 8'd0);
                chk("rst_pop_ready", 8'(pop_ready), 8'd0);
                chk("rst_ram_we", 8'(ram_we), 8'd0);
                chk("rst_ram_re", 8'(ram_re), 8'd0);
                chk("rst_valid", 8'(pop_data_valid), 8'd0);
                chk("rst_empty", 8'(empty), 8'd1);
                chk("rst_full", 8'(full), 8'd0);
                chk("rst_addr", 8'(ram_addr), 8'd0);
                chk("rst_wdata", ram_wdata, 8'd0);
            end else begin
                g = exp_grant();
                chk("push_ready", 8'(push_ready), 8'(g == 1));
                chk("pop_ready", 8'(pop_ready), 8'(g == 2));
                chk("full", 8'(full), 8'(m_q.size() == 8));
                chk("empty", 8'(empty), 8'(m_q.size() == 0));
                chk("ram_we", 8'(ram_we), 8'(m_we));
                chk("ram_re", 8'(ram_re), 8'(m_re));
                chk("ram_addr", 8'(ram_addr), 8'(m_addr));
                chk("ram_wdata", ram_wdata, m_wdata);
                chk("pop_valid", 8'(pop_data_valid), 8'(m_valid));
                if (m_valid) chk("pop_data", pop_data, m_vdata);
`ifdef RAM_FIFO_CTRL_LEVEL_EN
                chk("level", 8'(level), 8'(m_q.size()));
                chk("almost_full", 8'(almost_full), 8'(m_q.size() >= 7));
`endif
                // Advance the model across the coming edge (inputs stay put until after it).
                m_valid = m_re;
                m_vdata = m_rd_word;
                m_we = (g == 1);
                m_re = (g == 2);
                if (g == 1) begin
                    m_addr = 3'(m_wr);
                    m_wdata = push_data;
                    m_q.push_back(push_data);
                    m_wr = (m_wr + 1) % 8;
                    m_last_wr = 1;
                end else if (g == 2) begin
                    m_addr = 3'(m_rd);
                    m_rd_word = m_q.pop_front();
                    m_rd = (m_rd + 1) % 8;
                    m_last_wr = 0;
                end
            end
        end
    end

    // Drive one cycle of inputs, let one edge pass, return 1 time unit after it.
    task automatic cyc(input logic pv, input logic [7:0] pd, input logic pr);
        push_valid = pv;
        push_data  = pd;
        pop_req    = pr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        push_valid = 1'b0;
        pop_req    = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        push_valid = 1'b1;
        push_data = 8'h00;
        pop_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        push_valid = 1'b0;
        pop_req = 1'b0;
        rst_n = 1'b1;

        // Three pushes then three pops; data returns two edges after acceptance.
        cyc(1'b1, 8'hAA, 1'b0);
        cyc(1'b1, 8'hBB, 1'b0);
        cyc(1'b1, 8'hCC, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("t1_re", 8'(ram_re), 8'd1);
        chk("t1_addr0", 8'(ram_addr), 8'd0);
        chk("t1_no_valid_yet", 8'(pop_data_valid), 8'd0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("t1_data_aa", pop_data, 8'hAA);
        cyc(1'b0, 8'h00, 1'b1);
        chk("t1_data_bb", pop_data, 8'hBB);
        cyc(1'b0, 8'h00, 1'b0);
        chk("t1_data_cc", pop_data, 8'hCC);
        chk("t1_empty", 8'(empty), 8'd1);

        // Fill to full, hold a 9th push, pop one, then the held push wraps to address 0.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
        chk("t2_full", 8'(full), 8'd1);
        push_valid = 1'b1;
        push_data = 8'h18;
        pop_req = 1'b1;
        #1;
        chk("t2_push_held", 8'(push_ready), 8'd0);
        chk("t2_pop_ok", 8'(pop_ready), 8'd1);
        @(posedge clk);
        #1;
        pop_req = 1'b0;
        #1;
        chk("t2_push_now", 8'(push_ready), 8'd1);
        @(posedge clk);
        #1;
        push_valid = 1'b0;
        chk("t2_wrap_we", 8'(ram_we), 8'd1);
        chk("t2_wrap_addr", 8'(ram_addr), 8'd0);
        chk("t2_pop_10", pop_data, 8'h10);

        // Half full, both sides requesting: grants alternate starting with write.
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) begin
            push_valid = 1'b1;
            push_data = 8'(8'h20 + i);
            pop_req = 1'b1;
            #1;
            chk("t3_alt_wr", 8'(push_ready), 8'((i % 2) == 0));
            chk("t3_alt_rd", 8'(pop_ready), 8'((i % 2) == 1));
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("t3_drained", 8'(empty), 8'd1);

        // Pop from empty is refused; a push is poppable on the next edge.
        pop_req = 1'b1;
        #1;
        chk("t4_empty_pop", 8'(pop_ready), 8'd0);
        @(posedge clk);
        #1;
        pop_req = 1'b0;
        chk("t4_no_re", 8'(ram_re), 8'd0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("t4_no_valid", 8'(pop_data_valid), 8'd0);
        cyc(1'b1, 8'h5A, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("t4_valid", 8'(pop_data_valid), 8'd1);
        chk("t4_data_5a", pop_data, 8'h5A);

        // Reset while a read is in flight drops it.
        cyc(1'b1, 8'h77, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("t5_re_inflight", 8'(ram_re), 8'd1);
        pop_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_re_dropped", 8'(ram_re), 8'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("t5_no_valid", 8'(pop_data_valid), 8'd0);
        chk("t5_empty", 8'(empty), 8'd1);
        rst_n = 1'b1;
        cyc(1'b1, 8'h33, 1'b0);
        chk("t5_wr_ptr0", 8'(ram_addr), 8'd0);
        chk("t5_we", 8'(ram_we), 8'd1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("t5_rd_ptr0", 8'(ram_addr), 8'd0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("t5_data_33", pop_data, 8'h33);

`ifdef RAM_FIFO_CTRL_LEVEL_EN
        do_reset();
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
        chk("t6_level", 8'(level), 8'd7);
        chk("t6_almost_full", 8'(almost_full), 8'd1);
        chk("t6_not_full", 8'(full), 8'd0);
`endif

        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Single-port FIFO controller sitting directly upstream of the 8x8 `ram` block. It owns the write/read pointers and occupancy and arbitrates push and pop requests onto the RAM's single address port, one access per cycle. It drives `ram` through `we`/`re`/`addr`/`data_in` and returns `ram` read data to the consumer with a valid pulse.

## Interface
- `DATA_W`, 8, word width; must match `ram` data width
- `ADDR_W`, 3, RAM address width; depth = 2**ADDR_W = 8

Ports:
- `clk`  in  1  rising-edge clock, shared with `ram`
- `rst_n`  in  1  asynchronous, active-low reset
- `push_valid`  in  1  producer has a word
- `push_data`  in  DATA_W  word to enqueue
- `push_ready`  out  1  push accepted this cycle (combinational from requests and state)
- `pop_req`  in  1  consumer requests one word
- `pop_ready`  out  1  pop accepted this cycle (combinational)
- `pop_data`  out  DATA_W  the `ram` `data_out` pass-through
- `pop_data_valid`  out  1  one-cycle pulse; `pop_data` is valid
- `full`, `empty`  out  1 each  occupancy flags
- `ram_we`, `ram_re`  out  1 each  to `ram` `we`/`re`
- `ram_addr`  out  ADDR_W  to `ram` `addr`
- `ram_wdata`  out  DATA_W  to `ram` `data_in`
- `ram_rdata`  in  DATA_W  from `ram` `data_out`

## Operation
- Eligibility: push eligible = `push_valid && !full`; pop eligible = `pop_req && !empty`.
- Arbiter: one grant per cycle. If only one request is eligible, it wins. If both are eligible, the side not served last wins; the `last_grant` register updates on every grant and resets to RD, so the first contested cycle goes to write.
- `push_ready` / `pop_ready` equal the grant; the handshake completes on the edge where valid/req and ready are both high.
- Accepted push at edge N: registers `ram_we=1`, `ram_addr=wr_ptr`, `ram_wdata=push_data`; `wr_ptr` increments; `count` increments.
- Accepted pop at edge N: registers `ram_re=1`, `ram_addr=rd_ptr`; `rd_ptr` increments; `count` decrements.
- Pointers are ADDR_W bits and wrap 7→0. `count` is ADDR_W+1 bits, range 0..8. `full = (count==8)`, `empty = (count==0)`, both decoded from registered `count`.
- Same-cycle push and pop cannot both occur. `count` therefore changes by at most ±1 per cycle.
- Idle cycles: `ram_we=ram_re=0`; `ram_addr` and `ram_wdata` hold their last values.

## Timing
- Reset (asynchronous, while `rst_n=0`): `wr_ptr=rd_ptr=0`, `count=0`, `empty=1`, `full=0`, `ram_we=ram_re=0`, `ram_addr=0`, `ram_wdata=0`, `pop_data_valid=0`, `last_grant=RD`. `push_ready`/`pop_ready` are 0 while in reset.
- Write latency: push accepted at edge N; `ram` stores at edge N+1.
- Read latency: pop accepted at edge N; `ram_re` high N→N+1; `ram` updates `data_out` at edge N+1; `pop_data_valid` is high for exactly the cycle after edge N+1. Total: 2 edges from acceptance.
- Read-after-write safety: a word pushed at edge N is poppable at edge N+1 at the earliest. The read then issues at N+2, after the RAM write at N+1.
- Full: `push_ready=0` regardless of arbitration. Empty: `pop_ready=0`.
- Reset mid-operation: in-flight `ram_we`/`ram_re` are dropped immediately. Stored contents are lost logically (pointers cleared). A pending `pop_data_valid` does not fire.

## Configuration
- `RAM_FIFO_CTRL_LEVEL_EN`: when defined, adds output `level` [ADDR_W:0] (= `count`) and `almost_full` (`count >= 2**ADDR_W-1`).
- When undefined, these ports and logic are absent; all other behaviour is identical.

## Structure
- Package `ram_fifo_pkg`: `DATA_W`/`ADDR_W` defaults, `DEPTH` constant, `grant_t` enum {GNT_NONE, GNT_WR, GNT_RD}.
- Sub-module `ram_fifo_arb`: 2-way round-robin arbiter holding `last_grant`; inputs are the two eligibility signals, output is `grant_t`.
- Top holds pointers, `count`, RAM-side registers and the `pop_data_valid` pipeline (2 stages).

## Test plan
- Reset then push AA, BB, CC on consecutive cycles, then pop ×3 → `pop_data` AA, BB, CC. Each `pop_data_valid` arrives 2 edges after its acceptance; `empty=1` at the end.
- Push 8 words 0x10..0x17 → `full=1`; 9th push held with `push_ready=0`. Pop one → 0x10 returned; the held push then accepted at `ram_addr=0` (wrap).
- `push_valid` and `pop_req` both held high with the FIFO half full → grants alternate WR, RD, WR, RD; `count` stays within ±1 of its start value.
- Pop from empty → `pop_ready=0`, no `ram_re`, no `pop_data_valid`. Push 0x5A, then pop on the next edge → 0x5A returned.
- Assert `rst_n=0` one cycle after a pop is accepted → `ram_re` drops immediately, no `pop_data_valid`, `empty=1`, pointers 0.
- With `RAM_FIFO_CTRL_LEVEL_EN`: 7 pushes → `level=7`, `almost_full=1`, `full=0`.
